regfile_sb: RTL and testbench

Parametrised register file with per-register scoreboard. Two read ports with registered outputs, one write port, and a reservation port that marks registers as awaiting a pending write. Reads of a reserved register stall until the producing write lands, and same-cycle writes are forwarded to the reads. Sits between decode (reserve, read) and writeback (write) in the pipelined datapath, replacing the flat unparametrised register file.

---
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard: two registered read ports,
// one write port with same-cycle forwarding, and a reservation port.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              rd_stall_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  wr_hit, rsv_hit;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;

  logic wr_ok, rsv_ok;
  logic zero_a, zero_b;
  logic eff_busy_a, eff_busy_b;
  logic accept;
  logic cnt_inc, cnt_dec;

  // Register 0 is hard-wired to zero, so writes and reservations to it vanish.
  assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i  == '0));
  assign rsv_ok = rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));
  assign zero_a = (ZERO_REG != 0) && (rd_addr_a_i == '0);
  assign zero_b = (ZERO_REG != 0) && (rd_addr_b_i == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign wr_hit[gi]  = wr_ok  && (wr_addr_i  == ADDR_W'(gi));
      assign rsv_hit[gi] = rsv_ok && (rsv_addr_i == ADDR_W'(gi));
      // Reservation is applied after the write clear: the new producer wins.
      assign busy_d[gi]  = rsv_hit[gi] ? 1'b1 : (wr_hit[gi] ? 1'b0 : busy_q[gi]);
    end
  endgenerate

  assign eff_busy_a = busy_q[rd_addr_a_i] && !(wr_ok && (wr_addr_i == rd_addr_a_i));
  assign eff_busy_b = busy_q[rd_addr_b_i] && !(wr_ok && (wr_addr_i == rd_addr_b_i));
  assign rd_stall_o = rd_en_i && (eff_busy_a || eff_busy_b);
  assign accept     = rd_en_i && !rd_stall_o;

  always_comb begin
    rd_valid_d  = accept;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (accept) begin
      if (zero_a)                                   rd_data_a_d = '0;
      else if (wr_ok && (wr_addr_i == rd_addr_a_i)) rd_data_a_d = wr_data_i;
      else                                          rd_data_a_d = regs_q[rd_addr_a_i];
      if (zero_b)                                   rd_data_b_d = '0;
      else if (wr_ok && (wr_addr_i == rd_addr_b_i)) rd_data_b_d = wr_data_i;
      else                                          rd_data_b_d = regs_q[rd_addr_b_i];
    end
  end

  // Incremental population count; a write and reservation on one register never decrements.
  always_comb begin
    cnt_inc    = rsv_ok && !busy_q[rsv_addr_i];
    cnt_dec    = wr_ok && busy_q[wr_addr_i] && !(rsv_ok && (rsv_addr_i == wr_addr_i));
    busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_data_a_o = rd_data_a_q;
  assign rd_data_b_o = rd_data_b_q;
  assign busy_cnt_o  = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic,
// checked against an array-based reference model.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              rd_en_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a_i = '0, rd_addr_b_i = '0;
  logic              rd_stall_o, rd_valid_o;
  logic [DATA_W-1:0] rd_data_a_o, rd_data_b_o;
  logic              wr_en_i = 1'b0;
  logic [ADDR_W-1:0] wr_addr_i = '0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              rsv_en_i = 1'b0;
  logic [ADDR_W-1:0] rsv_addr_i = '0;
  logic [ADDR_W:0]   busy_cnt_o;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_en_i(rd_en_i), .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i),
    .rd_stall_o(rd_stall_o), .rd_valid_o(rd_valid_o),
    .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: architectural register contents and busy flags.
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_busy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    exp_a_q.delete();
    exp_b_q.delete();
  endfunction

  // Value a source address delivers this cycle, including write forwarding.
  function automatic logic [DATA_W-1:0] m_src(input int x, input bit we, input int wa,
                                               input logic [DATA_W-1:0] wd);
    if (x == 0) return '0;
    if (we && wa == x) return wd;
    return m_regs[x];
  endfunction

  task automatic cycle(input bit re, input int a, input int b,
                       input bit we, input int wa, input logic [DATA_W-1:0] wd,
                       input bit rs, input int ra);
    bit stall_a, stall_b, exp_stall;
    @(negedge clk_i);
    rd_en_i = re; rd_addr_a_i = a[ADDR_W-1:0]; rd_addr_b_i = b[ADDR_W-1:0];
    wr_en_i = we; wr_addr_i = wa[ADDR_W-1:0]; wr_data_i = wd;
    rsv_en_i = rs; rsv_addr_i = ra[ADDR_W-1:0];
    #1;
    stall_a   = m_busy[a] && !(we && wa == a);
    stall_b   = m_busy[b] && !(we && wa == b);
    exp_stall = re && (stall_a || stall_b);
    chk("rd_stall", {63'd0, rd_stall_o}, {63'd0, exp_stall});
    if (re && !exp_stall) begin
      exp_a_q.push_back(m_src(a, we, wa, wd));
      exp_b_q.push_back(m_src(b, we, wa, wd));
    end
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_busy[wa] = 0;
    end
    if (rs && ra != 0) m_busy[ra] = 1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  // Monitor: pops one expectation per rd_valid and tracks held data otherwise.
  initial begin : monitor
    logic [DATA_W-1:0] hold_a, hold_b, ea, eb;
    hold_a = '0; hold_b = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_a = '0; hold_b = '0;
      end else begin
        chk("busy_cnt", {58'd0, busy_cnt_o}, 64'(m_count()));
        if (rd_valid_o) begin
          if (exp_a_q.size() == 0) begin
            chk("unexpected_rd_valid", 64'd1, 64'd0);
          end else begin
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            $display("read result a=0x%08h b=0x%08h (expected 0x%08h 0x%08h)",
                     rd_data_a_o, rd_data_b_o, ea, eb);
            chk("rd_data_a", {32'd0, rd_data_a_o}, {32'd0, ea});
            chk("rd_data_b", {32'd0, rd_data_b_o}, {32'd0, eb});
            hold_a = ea; hold_b = eb;
          end
        end else begin
          if (exp_a_q.size() != 0) begin
            chk("missing_rd_valid", 64'd0, 64'd1);
            void'(exp_a_q.pop_front());
            void'(exp_b_q.pop_front());
          end
          chk("hold_a", {32'd0, rd_data_a_o}, {32'd0, hold_a});
          chk("hold_b", {32'd0, rd_data_b_o}, {32'd0, hold_b});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    m_clear();
    #1;
    chk("reset_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("reset_busy_cnt", {58'd0, busy_cnt_o}, 64'd0);
    repeat (2) @(negedge clk_i);
    #3 rst_i = 1'b0;

    // Read after reset returns zeros.
    cycle(1, 3, 4, 0, 0, '0, 0, 0);
    // Write then read, and forwarding in the write cycle.
    cycle(0, 0, 0, 1, 5, 32'h1234, 0, 0);
    cycle(1, 5, 5, 0, 0, '0, 0, 0);
    cycle(1, 5, 6, 1, 5, 32'h5678, 0, 0);
    // Reserve r7, stall twice, release on the write.
    cycle(0, 0, 0, 0, 0, '0, 1, 7);
    cycle(1, 7, 0, 0, 0, '0, 0, 0);
    cycle(1, 7, 0, 0, 0, '0, 0, 0);
    cycle(1, 7, 0, 1, 7, 32'hAA, 0, 0);
    // Register 0 ignores write and reservation.
    cycle(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
    cycle(1, 0, 5, 0, 0, '0, 0, 0);
    // Simultaneous write and reservation of r9.
    cycle(0, 0, 0, 0, 0, '0, 1, 9);
    cycle(0, 0, 0, 1, 9, 32'h55, 1, 9);
    cycle(1, 9, 3, 0, 0, '0, 0, 0);
    cycle(0, 0, 0, 1, 9, 32'h66, 0, 0);
    cycle(1, 3, 9, 0, 0, '0, 0, 0);
    // Reserve r1..r3, then reset in the middle of a stalled read.
    cycle(0, 0, 0, 0, 0, '0, 1, 1);
    cycle(0, 0, 0, 0, 0, '0, 1, 2);
    cycle(0, 0, 0, 0, 0, '0, 1, 3);
    cycle(1, 2, 2, 0, 0, '0, 0, 0);
    #2 rst_i = 1'b1;
    rd_en_i = 0; wr_en_i = 0; rsv_en_i = 0;
    #1;
    m_clear();
    chk("midrst_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("midrst_data_a", {32'd0, rd_data_a_o}, 64'd0);
    chk("midrst_data_b", {32'd0, rd_data_b_o}, 64'd0);
    chk("midrst_busy_cnt", {58'd0, busy_cnt_o}, 64'd0);
    @(negedge clk_i);
    #3 rst_i = 1'b0;
    cycle(1, 2, 5, 0, 0, '0, 0, 0);

    // Random traffic, mostly on a small address window to force collisions.
    for (int i = 0; i < 500; i++) begin
      int a, b, wa, ra;
      bit re, we, rs;
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
      b  = int'($urandom_range(0, 7));
      wa = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH-1)) : int'($urandom_range(0, 7));
      re = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0);
      rs = ($urandom_range(0, 2) == 0);
      cycle(re, a, b, we, wa, $urandom, rs, ra);
    end

    idle();
    idle();
    idle();
    chk("queue_drained", 64'(exp_a_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
